// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction FIFO.
package branch_resolve_unit_pkg;

  localparam int unsigned DEFAULT_DEPTH     = 4;
  localparam int unsigned DEFAULT_PHT_IDX_W = 5;
  localparam logic [1:0]  PHT_RESET         = 2'b01;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_entry_t;

  // 2-bit saturating counter step
  function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : 2'(ctr + 2'd1);
    else       return (ctr == 2'b00) ? 2'b00 : 2'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order FIFO of in-flight fetch predictions; clear drops every entry at once.
module branch_resolve_unit_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t wr_data,
  output pred_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pred_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-flight fetch predictions against EX resolution; drives flush/redirect,
// BTB update and the 2-bit pattern history table read by fetch.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned PHT_IDX_W = DEFAULT_PHT_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_pc,
  input  logic        push_pred_taken,
  input  logic [31:0] push_pred_target,
  input  logic        resolve_valid,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_source_pc,
  output logic [31:0] upd_target_pc,
  output logic        upd_branch_taken,
  output logic        err_underflow
);

  localparam int unsigned PHT_SIZE = 1 << PHT_IDX_W;

  pred_entry_t          head;
  pred_entry_t          wr_entry;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 resolve_fire;
  logic                 mispredict;
  logic                 upd_fire;
  logic                 squash;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic [PHT_IDX_W-1:0] lookup_idx;
  logic [1:0]           pht [PHT_SIZE];
  logic                 unused_lookup_bits;

  assign wr_entry     = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};
  assign push_ready   = !fifo_full;
  assign resolve_fire = resolve_valid && !fifo_empty;

  // A false BTB hit on a non-branch is also a mispredict
  assign mispredict = resolve_is_branch
                      ? ((resolve_taken != head.pred_taken) ||
                         (resolve_taken && (resolve_target != head.pred_target)))
                      : head.pred_taken;
  assign upd_fire   = resolve_is_branch || head.pred_taken;
  assign squash     = resolve_fire && mispredict;

  assign upd_idx            = head.pc[PHT_IDX_W+1:2];
  assign lookup_idx         = lookup_pc[PHT_IDX_W+1:2];
  assign lookup_taken       = pht[lookup_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0]};

  branch_resolve_unit_pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_valid && !squash),
    .pop     (resolve_fire),
    .clear   (squash),
    .wr_data (wr_entry),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Resolve outputs, sticky underflow flag and PHT training
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush            <= 1'b0;
      redirect_pc      <= '0;
      upd_valid        <= 1'b0;
      upd_source_pc    <= '0;
      upd_target_pc    <= '0;
      upd_branch_taken <= 1'b0;
      err_underflow    <= 1'b0;
      for (int i = 0; i < int'(PHT_SIZE); i++) pht[i] <= PHT_RESET;
    end else begin
      flush     <= squash;
      upd_valid <= resolve_fire && upd_fire;
      if (squash)
        redirect_pc <= (resolve_is_branch && resolve_taken) ? resolve_target
                                                             : 32'(head.pc + PC_STEP);
      if (resolve_fire && upd_fire) begin
        upd_source_pc    <= head.pc;
        upd_target_pc    <= resolve_target;
        upd_branch_taken <= resolve_is_branch && resolve_taken;
      end
      if (resolve_valid && fifo_empty) err_underflow <= 1'b1;
      if (resolve_fire && resolve_is_branch)
        pht[upd_idx] <= pht_next(pht[upd_idx], resolve_taken);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random stimulus against a queue/array reference model of the resolve unit.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_source_pc;
  logic [31:0] upd_target_pc;
  logic        upd_branch_taken;
  logic        err_underflow;

  branch_resolve_unit dut (
    .clk               (clk),
    .reset             (reset),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_pc           (push_pc),
    .push_pred_taken   (push_pred_taken),
    .push_pred_target  (push_pred_target),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_target    (resolve_target),
    .lookup_pc         (lookup_pc),
    .lookup_taken      (lookup_taken),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .upd_valid         (upd_valid),
    .upd_source_pc     (upd_source_pc),
    .upd_target_pc     (upd_target_pc),
    .upd_branch_taken  (upd_branch_taken),
    .err_underflow     (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          pht[32];
  bit          m_flush, m_upd, m_ubt, m_err;
  logic [31:0] m_redir, m_src, m_tgt;
  int          checks = 0;
  int          failures = 0;

  function automatic int pidx(input logic [31:0] a);
    return int'((a >> 2) % 32);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("flush", 32'(flush), 32'(m_flush));
    chk("redirect_pc", redirect_pc, m_redir);
    chk("upd_valid", 32'(upd_valid), 32'(m_upd));
    chk("upd_source_pc", upd_source_pc, m_src);
    chk("upd_target_pc", upd_target_pc, m_tgt);
    chk("upd_branch_taken", 32'(upd_branch_taken), 32'(m_ubt));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b0; push_valid = 1'b0; resolve_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    foreach (pht[i]) pht[i] = 1;
    m_flush = 0; m_upd = 0; m_ubt = 0; m_err = 0;
    m_redir = '0; m_src = '0; m_tgt = '0;
    chk_outputs();
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs
  task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input logic [31:0] ptgt,
                      input bit rv, input bit isb, input bit tk, input logic [31:0] tgt,
                      input logic [31:0] lpc);
    ent_t h;
    bit   mis;
    bit   popped;
    bit   was_full;
    push_valid = pv; push_pc = pc; push_pred_taken = pt; push_pred_target = ptgt;
    resolve_valid = rv; resolve_is_branch = isb; resolve_taken = tk; resolve_target = tgt;
    lookup_pc = lpc;
    #1;
    chk("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
    chk("lookup_taken", 32'(lookup_taken), 32'(pht[pidx(lpc)] >= 2));
    was_full = (q.size() == DEPTH);
    m_flush = 0; m_upd = 0; mis = 0; popped = 0;
    if (rv && q.size() > 0) begin
      h = q.pop_front();
      popped = 1;
      if (isb) mis = (tk != h.pt) || (tk && tgt != h.tgt);
      else     mis = h.pt;
      m_flush = mis;
      m_upd = isb || h.pt;
      if (mis) m_redir = (isb && tk) ? tgt : h.pc + 32'd4;
      if (m_upd) begin m_src = h.pc; m_tgt = tgt; m_ubt = isb && tk; end
      if (isb) begin
        if (tk) pht[pidx(h.pc)] = (pht[pidx(h.pc)] < 3) ? pht[pidx(h.pc)] + 1 : 3;
        else    pht[pidx(h.pc)] = (pht[pidx(h.pc)] > 0) ? pht[pidx(h.pc)] - 1 : 0;
      end
      if (mis) q.delete();
    end else if (rv) begin
      m_err = 1;
    end
    if (pv && !was_full && !(popped && mis)) q.push_back('{pc, pt, ptgt});
    @(posedge clk); #1;
    chk_outputs();
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(0, 0, 0, 0, 0, 0, 0, 0, lpc);
  endtask

  logic [31:0] pcs [6];
  logic [31:0] tgts [3];

  initial begin
    pcs  = '{32'h100, 32'h104, 32'h180, 32'h200, 32'h300, 32'hFFFF_FFFC};
    tgts = '{32'h200, 32'h400, 32'h0};
    reset = 1'b1; push_valid = 0; push_pc = 0; push_pred_taken = 0; push_pred_target = 0;
    resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = 0; lookup_pc = 0;
    do_reset();

    // Disturb counter at 0x40, then reset and confirm it returns to weakly not-taken
    step(1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h40);
    step(1, 32'h40, 1, 32'h80, 1, 1, 0, 0, 32'h40);
    step(0, 0, 0, 0, 1, 1, 1, 32'h80, 32'h40);
    idle(32'h40);
    do_reset();
    idle(32'h40);

    // Mispredict: predicted not-taken, resolved taken
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 1, 1, 1, 32'h200, 32'h100);
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_redirect", redirect_pc, 32'h200);
    idle(32'h100);

    // Correct prediction then a plain non-branch
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 32'h100);
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 32'h204, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 1, 1, 1, 32'h200, 32'h100);
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h100);
    idle(32'h100);

    // Fill, overflow push, then mispredict squash with a simultaneous push
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 32'h104);
    step(1, 32'h500, 0, 0, 1, 1, 1, 32'h400, 32'h104);
    idle(32'h104);

    // False BTB hit on a non-branch
    step(1, 32'h300, 1, 32'h400, 0, 0, 0, 0, 32'h300);
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h300);
    chk("fh_redirect", redirect_pc, 32'h304);

    // Underflow, including a push into an empty FIFO in the same cycle
    step(0, 0, 0, 0, 1, 1, 1, 32'h200, 32'h300);
    step(1, 32'h180, 0, 0, 1, 1, 0, 0, 32'h300);
    idle(32'h180);

    // Saturation: four taken then one not-taken at the same index
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h180, 1, 32'h400, 0, 0, 0, 0, 32'h180);
      step(0, 0, 0, 0, 1, 1, 1, 32'h400, 32'h180);
    end
    step(1, 32'h180, 1, 32'h400, 0, 0, 0, 0, 32'h180);
    step(0, 0, 0, 0, 1, 1, 0, 0, 32'h180);
    idle(32'h180);
    idle(32'hFFFF_FFFC);

    // Random traffic with a reset every so often
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      step(1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
           tgts[$urandom_range(0, 2)], 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)], pcs[$urandom_range(0, 5)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
